// File: rtl/tb_sram_lat_pkg.sv
// tb_sram_lat_pkg: shared constants, types and the byte-merge helper for the
// tb_sram_lat SRAM model.
package tb_sram_lat_pkg;

    // Deepest read pipeline the model supports (request edge to rvalid_o).
    localparam int MAX_READ_LATENCY = 8;

    // Widest word the byte-merge helper handles; callers cast to/from it.
    localparam int MAX_DATA_WIDTH = 512;

    // Access counter type.
    typedef logic [31:0] cnt_t;

    typedef logic [MAX_DATA_WIDTH-1:0]   word_max_t;
    typedef logic [MAX_DATA_WIDTH/8-1:0] be_max_t;

    // Replace the bytes of old_word selected by be with those of new_word.
    function automatic word_max_t be_merge(word_max_t old_word, word_max_t new_word, be_max_t be);
        word_max_t merged;
        merged = old_word;
        for (int k = 0; k < MAX_DATA_WIDTH / 8; k++) begin
            if (be[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return merged;
    endfunction

    // Increment that sticks at the all-ones value.
    function automatic cnt_t cnt_sat_inc(cnt_t c);
        return (c == '1) ? c : c + cnt_t'(1);
    endfunction

endpackage

// File: rtl/tb_sram_lat_rd_pipe.sv
// sram_rd_pipe: delay line of DEPTH stages, each holding a valid bit and a
// data word. Stage data only reloads when a valid word enters it, so the
// output keeps the last delivered word while valid_o is low. DEPTH=0 is a
// pure wire.
module sram_rd_pipe #(
    parameter int DEPTH      = 1,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    if (DEPTH == 0) begin : g_wire
        // Clock and reset have no load when there are no stages.
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_ni;
        assign valid_o = valid_i;
        assign data_o  = data_i;
    end else begin : g_regs
        logic [DEPTH-1:0]      valid_q;
        logic [DATA_WIDTH-1:0] data_q [DEPTH];

        // Shift valid every cycle; move data only alongside a valid bit.
        // NOTE: state registers use non-blocking assignments so every stage
        // samples its predecessor's value from before the edge.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    data_q[i] <= '0;
                end
            end else begin
                valid_q[0] <= valid_i;
                if (valid_i) begin
                    data_q[0] <= data_i;
                end
                for (int i = 1; i < DEPTH; i++) begin
                    valid_q[i] <= valid_q[i-1];
                    if (valid_q[i-1]) begin
                        data_q[i] <= data_q[i-1];
                    end
                end
            end
        end

        assign valid_o = valid_q[DEPTH-1];
        assign data_o  = data_q[DEPTH-1];
    end

endmodule

// File: rtl/tb_sram_lat.sv
// tb_sram_lat: single-port synchronous SRAM model with byte-enable writes,
// READ_LATENCY-cycle reads and a registered write-commit event.
// Optional feature: define TB_SRAM_LAT_STATS_EN to build the saturating
// n_reads_o / n_writes_o access counters (tied to 0 otherwise).
module tb_sram_lat
    import tb_sram_lat_pkg::*;
#(
    parameter int ADDR_WIDTH   = 20,
    parameter int DATA_WIDTH   = 64,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    wr_valid_o,
    output logic [ADDR_WIDTH-1:0]   wr_addr_o,
    output logic [DATA_WIDTH-1:0]   wr_data_o,
    output logic [DATA_WIDTH/8-1:0] wr_be_o,
    output logic [31:0]             n_reads_o,
    output logic [31:0]             n_writes_o
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int DEPTH    = 2 ** ADDR_WIDTH;

    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
        $error("tb_sram_lat: READ_LATENCY %0d outside 1..%0d", READ_LATENCY, MAX_READ_LATENCY);
    end
    if (DATA_WIDTH % 8 != 0 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
        $error("tb_sram_lat: DATA_WIDTH %0d must be a multiple of 8 and <= %0d",
               DATA_WIDTH, MAX_DATA_WIDTH);
    end

    logic rd_req;
    logic wr_req;
    assign rd_req = req_i & ~we_i;
    assign wr_req = req_i & we_i;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] merged_word;

    // Word as it will look after this write: old bytes kept where be_i is 0.
    assign merged_word = DATA_WIDTH'(be_merge(word_max_t'(mem_q[addr_i]),
                                              word_max_t'(wdata_i),
                                              be_max_t'(be_i)));

    // Storage array update on writes.
    // NOTE: the array has no reset on purpose; its contents must survive rst_ni,
    // and resetting a large memory would not map onto a RAM macro anyway.
    always_ff @(posedge clk_i) begin
        if (wr_req) begin
            mem_q[addr_i] <= merged_word;
        end
    end

    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    // First read stage: sample the array at the request edge; data holds between reads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_req;
            if (rd_req) begin
                rd_data_q <= mem_q[addr_i];
            end
        end
    end

    sram_rd_pipe #(
        .DEPTH      (READ_LATENCY - 1),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_pipe (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (rd_valid_q),
        .data_i  (rd_data_q),
        .valid_o (rvalid_o),
        .data_o  (rdata_o)
    );

    // Write-commit event: one-cycle pulse with the committed address, word and enables.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_valid_o <= 1'b0;
            wr_addr_o  <= '0;
            wr_data_o  <= '0;
            wr_be_o    <= '0;
        end else begin
            wr_valid_o <= wr_req;
            if (wr_req) begin
                wr_addr_o <= addr_i;
                wr_data_o <= merged_word;
                wr_be_o   <= be_i;
            end
        end
    end

`ifdef TB_SRAM_LAT_STATS_EN
    cnt_t n_reads_q;
    cnt_t n_writes_q;

    // Saturating per-direction access counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            n_reads_q  <= '0;
            n_writes_q <= '0;
        end else begin
            if (rd_req) begin
                n_reads_q <= cnt_sat_inc(n_reads_q);
            end
            if (wr_req) begin
                n_writes_q <= cnt_sat_inc(n_writes_q);
            end
        end
    end

    assign n_reads_o  = n_reads_q;
    assign n_writes_o = n_writes_q;
`else
    assign n_reads_o  = '0;
    assign n_writes_o = '0;
`endif

    logic [BE_WIDTH-1:0] unused_be_width;
    assign unused_be_width = '0;

endmodule

// File: tb/tb_tb_sram_lat.sv
// tb_tb_sram_lat: self-checking bench for tb_sram_lat. Two instances share
// clock and reset: dut0 with READ_LATENCY=1, dut1 with READ_LATENCY=4.
// Counter expectations follow TB_SRAM_LAT_STATS_EN.
module tb_tb_sram_lat;

    localparam int AW = 8;
    localparam int DW = 64;
    localparam int BW = DW / 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic          req      [2];
    logic          we       [2];
    logic [AW-1:0] addr     [2];
    logic [BW-1:0] be       [2];
    logic [DW-1:0] wdata    [2];
    logic          rvalid   [2];
    logic [DW-1:0] rdata    [2];
    logic          wr_valid [2];
    logic [AW-1:0] wr_addr  [2];
    logic [DW-1:0] wr_data  [2];
    logic [BW-1:0] wr_be    [2];
    logic [31:0]   n_reads  [2];
    logic [31:0]   n_writes [2];

    always #5 clk = ~clk;

    tb_sram_lat #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
        .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]),
        .wr_valid_o(wr_valid[0]), .wr_addr_o(wr_addr[0]), .wr_data_o(wr_data[0]),
        .wr_be_o(wr_be[0]), .n_reads_o(n_reads[0]), .n_writes_o(n_writes[0])
    );

    tb_sram_lat #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(4)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
        .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]),
        .wr_valid_o(wr_valid[1]), .wr_addr_o(wr_addr[1]), .wr_data_o(wr_data[1]),
        .wr_be_o(wr_be[1]), .n_reads_o(n_reads[1]), .n_writes_o(n_writes[1])
    );

    // Reference model: word array, per-edge delivery schedule, last delivered word,
    // expected write event and access counts.
    logic [DW-1:0] ref_mem [2][256];
    logic          sched_v [2][16];
    logic [DW-1:0] sched_d [2][16];
    logic [DW-1:0] last_rd [2];
    logic          exp_wv  [2];
    logic [AW-1:0] exp_wa  [2];
    logic [DW-1:0] exp_wd  [2];
    logic [BW-1:0] exp_wb  [2];
    logic [31:0]   cnt_r   [2];
    logic [31:0]   cnt_w   [2];
    int            edge_n = 0;

    int n_vec = 0;
    int n_err = 0;

    function automatic int rl_of(int i);
        return (i == 0) ? 1 : 4;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_idle(input int i);
        req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; be[i] = '0; wdata[i] = '0;
    endtask

    task automatic set_op(input int i, input logic w, input logic [AW-1:0] a,
                          input logic [BW-1:0] b, input logic [DW-1:0] d);
        req[i] = 1'b1; we[i] = w; addr[i] = a; be[i] = b; wdata[i] = d;
    endtask

    // Apply the accesses presented at this edge to the model.
    task automatic model_edge(input int i);
        logic [DW-1:0] w;
        logic [3:0]    slot;
        exp_wv[i] = 1'b0;
        if (rst_n && req[i]) begin
            if (we[i]) begin
                w = ref_mem[i][addr[i]];
                for (int k = 0; k < BW; k++) begin
                    if (be[i][k]) w[8*k +: 8] = wdata[i][8*k +: 8];
                end
                ref_mem[i][addr[i]] = w;
                exp_wv[i] = 1'b1;
                exp_wa[i] = addr[i];
                exp_wd[i] = w;
                exp_wb[i] = be[i];
                if (cnt_w[i] != 32'hFFFF_FFFF) cnt_w[i] = cnt_w[i] + 1;
            end else begin
                slot = 4'(edge_n + rl_of(i) - 1);
                sched_v[i][slot] = 1'b1;
                sched_d[i][slot] = ref_mem[i][addr[i]];
                if (cnt_r[i] != 32'hFFFF_FFFF) cnt_r[i] = cnt_r[i] + 1;
            end
        end
    endtask

    task automatic check_outputs(input int i);
        logic [3:0] slot;
        logic       exp_rv;
        slot   = 4'(edge_n);
        exp_rv = sched_v[i][slot];
        if (exp_rv) begin
            last_rd[i]       = sched_d[i][slot];
            sched_v[i][slot] = 1'b0;
        end
        check($sformatf("dut%0d rvalid @%0d", i, edge_n), 64'(rvalid[i]), 64'(exp_rv));
        check($sformatf("dut%0d rdata @%0d", i, edge_n), rdata[i], last_rd[i]);
        check($sformatf("dut%0d wr_valid @%0d", i, edge_n), 64'(wr_valid[i]), 64'(exp_wv[i]));
        if (exp_wv[i]) begin
            check($sformatf("dut%0d wr_addr @%0d", i, edge_n), 64'(wr_addr[i]), 64'(exp_wa[i]));
            check($sformatf("dut%0d wr_data @%0d", i, edge_n), wr_data[i], exp_wd[i]);
            check($sformatf("dut%0d wr_be @%0d", i, edge_n), 64'(wr_be[i]), 64'(exp_wb[i]));
        end
`ifdef TB_SRAM_LAT_STATS_EN
        check($sformatf("dut%0d n_reads @%0d", i, edge_n), 64'(n_reads[i]), 64'(cnt_r[i]));
        check($sformatf("dut%0d n_writes @%0d", i, edge_n), 64'(n_writes[i]), 64'(cnt_w[i]));
`else
        check($sformatf("dut%0d n_reads @%0d", i, edge_n), 64'(n_reads[i]), 64'd0);
        check($sformatf("dut%0d n_writes @%0d", i, edge_n), 64'(n_writes[i]), 64'd0);
`endif
    endtask

    // One clock: model the edge, then compare both instances 1 time unit later.
    task automatic step();
        @(posedge clk);
        edge_n++;
        for (int i = 0; i < 2; i++) model_edge(i);
        #1;
        for (int i = 0; i < 2; i++) check_outputs(i);
    endtask

    // Assert reset away from the clock edge, check reset values, hold for two edges.
    task automatic apply_reset();
        for (int i = 0; i < 2; i++) set_idle(i);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            for (int s = 0; s < 16; s++) sched_v[i][s] = 1'b0;
            last_rd[i] = '0;
            exp_wv[i]  = 1'b0;
            cnt_r[i]   = '0;
            cnt_w[i]   = '0;
            check($sformatf("dut%0d reset rvalid", i), 64'(rvalid[i]), 64'd0);
            check($sformatf("dut%0d reset rdata", i), rdata[i], 64'd0);
            check($sformatf("dut%0d reset wr_valid", i), 64'(wr_valid[i]), 64'd0);
            check($sformatf("dut%0d reset wr_addr", i), 64'(wr_addr[i]), 64'd0);
            check($sformatf("dut%0d reset wr_data", i), wr_data[i], 64'd0);
            check($sformatf("dut%0d reset wr_be", i), 64'(wr_be[i]), 64'd0);
            check($sformatf("dut%0d reset n_reads", i), 64'(n_reads[i]), 64'd0);
            check($sformatf("dut%0d reset n_writes", i), 64'(n_writes[i]), 64'd0);
        end
        step();
        step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic          req;
        logic          we;
        logic [AW-1:0] addr;
        logic [BW-1:0] be;
        logic [DW-1:0] wdata;
        logic          exp_rv;
        logic [DW-1:0] exp_rd;
        logic          exp_wv;
        logic [DW-1:0] exp_wd;
        logic [BW-1:0] exp_wb;
    } vec_t;

    vec_t tbl [8];

    initial begin : main
        int first_req;
        int first_pulse;
        int last_pulse;
        int pulses;

        // READ_LATENCY=1 directed vectors; outputs are observed right after the edge.
        tbl[0] = '{1'b1, 1'b1, 8'h10, 8'hFF, 64'h1122_3344_5566_7788,
                   1'b0, 64'h0, 1'b1, 64'h1122_3344_5566_7788, 8'hFF};
        tbl[1] = '{1'b1, 1'b0, 8'h10, 8'h00, 64'h0,
                   1'b1, 64'h1122_3344_5566_7788, 1'b0, 64'h0, 8'h00};
        tbl[2] = '{1'b1, 1'b1, 8'h10, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB,
                   1'b0, 64'h1122_3344_5566_7788, 1'b1, 64'h1122_3344_BBBB_BBBB, 8'h0F};
        tbl[3] = '{1'b1, 1'b0, 8'h10, 8'h00, 64'h0,
                   1'b1, 64'h1122_3344_BBBB_BBBB, 1'b0, 64'h0, 8'h00};
        tbl[4] = '{1'b0, 1'b0, 8'h00, 8'h00, 64'h0,
                   1'b0, 64'h1122_3344_BBBB_BBBB, 1'b0, 64'h0, 8'h00};
        tbl[5] = '{1'b1, 1'b1, 8'h03, 8'hFF, 64'h0123_4567_89AB_CDEF,
                   1'b0, 64'h1122_3344_BBBB_BBBB, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF};
        tbl[6] = '{1'b1, 1'b1, 8'h03, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF,
                   1'b0, 64'h1122_3344_BBBB_BBBB, 1'b1, 64'h0123_4567_89AB_CDEF, 8'h00};
        tbl[7] = '{1'b1, 1'b0, 8'h03, 8'h00, 64'h0,
                   1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0, 8'h00};

        for (int i = 0; i < 2; i++) set_idle(i);
        #2;
        apply_reset();

        // Give every word a known value in both instances.
        for (int a = 0; a < 256; a++) begin
            for (int i = 0; i < 2; i++)
                set_op(i, 1'b1, AW'(a), 8'hFF, {$urandom, $urandom});
            step();
        end
        for (int i = 0; i < 2; i++) set_idle(i);
        apply_reset();

        // Table-driven vectors on dut0.
        for (int r = 0; r < 8; r++) begin
            if (tbl[r].req) set_op(0, tbl[r].we, tbl[r].addr, tbl[r].be, tbl[r].wdata);
            else            set_idle(0);
            step();
            check($sformatf("tbl%0d rvalid", r), 64'(rvalid[0]), 64'(tbl[r].exp_rv));
            check($sformatf("tbl%0d rdata", r), rdata[0], tbl[r].exp_rd);
            check($sformatf("tbl%0d wr_valid", r), 64'(wr_valid[0]), 64'(tbl[r].exp_wv));
            if (tbl[r].exp_wv) begin
                check($sformatf("tbl%0d wr_data", r), wr_data[0], tbl[r].exp_wd);
                check($sformatf("tbl%0d wr_be", r), 64'(wr_be[0]), 64'(tbl[r].exp_wb));
            end
        end
        set_idle(0);

        // READ_LATENCY=4: six back-to-back reads of 0..5 on dut1.
        first_req   = edge_n + 1;
        first_pulse = -1;
        last_pulse  = -1;
        pulses      = 0;
        for (int c = 0; c < 14; c++) begin
            if (c < 6) set_op(1, 1'b0, AW'(c), 8'h00, 64'h0);
            else       set_idle(1);
            step();
            if (rvalid[1]) begin
                if (first_pulse < 0) first_pulse = edge_n;
                last_pulse = edge_n;
                check($sformatf("b2b word %0d", pulses), rdata[1], ref_mem[1][pulses]);
                pulses++;
            end
        end
        check("b2b pulse count", 64'(pulses), 64'd6);
        check("b2b first pulse offset", 64'(first_pulse - first_req), 64'd3);
        check("b2b pulse span", 64'(last_pulse - first_pulse), 64'd5);

        // Reset with two reads in flight on dut1: nothing may be delivered.
        set_op(1, 1'b0, 8'h07, 8'h00, 64'h0);
        step();
        set_op(1, 1'b0, 8'h08, 8'h00, 64'h0);
        step();
        set_idle(1);
        step();
        apply_reset();
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (rvalid[1]) pulses++;
        end
        check("flushed reads", 64'(pulses), 64'd0);
        set_op(1, 1'b0, 8'h07, 8'h00, 64'h0);
        step();
        set_idle(1);
        for (int c = 0; c < 3; c++) step();
        check("post-reset read valid", 64'(rvalid[1]), 64'd1);
        check("post-reset read data", rdata[1], ref_mem[1][7]);

        // Counter behaviour: 3 reads and 2 writes on dut0.
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            set_op(0, (c == 1 || c == 3), AW'(c + 32), 8'hFF, {$urandom, $urandom});
            step();
        end
        set_idle(0);
        step();
`ifdef TB_SRAM_LAT_STATS_EN
        check("stats n_reads", 64'(n_reads[0]), 64'd3);
        check("stats n_writes", 64'(n_writes[0]), 64'd2);
        force dut0.n_reads_q = 32'hFFFF_FFFF;
        force dut0.n_writes_q = 32'hFFFF_FFFF;
        cnt_r[0] = 32'hFFFF_FFFF;
        cnt_w[0] = 32'hFFFF_FFFF;
        #1;
        release dut0.n_reads_q;
        release dut0.n_writes_q;
        set_op(0, 1'b0, 8'h20, 8'h00, 64'h0);
        step();
        set_op(0, 1'b1, 8'h21, 8'hFF, 64'h5A5A);
        step();
        set_idle(0);
        step();
        check("sat n_reads", 64'(n_reads[0]), 64'hFFFF_FFFF);
        check("sat n_writes", 64'(n_writes[0]), 64'hFFFF_FFFF);
`else
        check("stats off n_reads", 64'(n_reads[0]), 64'd0);
        check("stats off n_writes", 64'(n_writes[0]), 64'd0);
`endif

        // Randomised traffic on a narrow address window so write-then-read pairs occur.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 9) < 7)
                    set_op(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                           BW'($urandom_range(0, 255)), {$urandom, $urandom});
                else
                    set_idle(i);
            end
            step();
        end
        for (int i = 0; i < 2; i++) set_idle(i);
        for (int c = 0; c < 6; c++) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
